// File: rtl/bridge_req_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ single-beat requesters onto one AHB
// master port toward the bridge, with a bounded data-phase wait and error return.
module bridge_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                            hclk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*32-1:0]           req_addr,
    input  logic [NUM_REQ*3-1:0]            req_size,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [NUM_REQ-1:0]              err,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            hsel,
    output logic [1:0]                      htrans,
    output logic [31:0]                     haddr,
    output logic                            hwrite,
    output logic [2:0]                      hburst,
    output logic [2:0]                      hsize,
    output logic [DATA_WIDTH-1:0]           hwdata,
    input  logic                            hready,
    input  logic                            hresp,
    input  logic [DATA_WIDTH-1:0]           hrdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [1:0]            state_reg;
    logic [IDX_W-1:0]      last_reg;
    logic [7:0]            wait_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    logic [31:0]           addr_arr  [NUM_REQ];
    logic [2:0]            size_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    int                    cand;
    logic [IDX_W-1:0]      cand_idx;
    logic [7:0]            wait_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*32 +: 32];
            assign size_arr[gi]  = req_size[gi*3 +: 3];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First requesting index at or after the one following the last winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(last_reg) + 1 + k) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign wait_next = wait_reg + 8'd1;
    assign hburst    = 3'b000;

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            last_reg  <= IDX_W'(NUM_REQ - 1);
            wait_reg  <= '0;
            wdata_reg <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            hsel      <= 1'b0;
            htrans    <= HTRANS_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize     <= 3'b000;
            hwdata    <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt       <= NUM_REQ'(1) << pick_idx;
                        last_reg  <= pick_idx;
                        haddr     <= addr_arr[pick_idx];
                        hwrite    <= req_write[pick_idx];
                        hsize     <= size_arr[pick_idx];
                        wdata_reg <= wdata_arr[pick_idx];
                        hsel      <= 1'b1;
                        htrans    <= HTRANS_NONSEQ;
                        state_reg <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (hready) begin
                        hsel      <= 1'b0;
                        htrans    <= HTRANS_IDLE;
                        hwdata    <= hwrite ? wdata_reg : '0;
                        wait_reg  <= '0;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (hready) begin
                        done      <= gnt;
                        err       <= hresp ? gnt : '0;
                        rdata     <= hwrite ? '0 : hrdata;
                        gnt       <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        wait_reg <= wait_next;
                        // Abort on the edge where the count would reach TIMEOUT.
                        if (wait_next == 8'(TIMEOUT)) begin
                            done      <= gnt;
                            err       <= gnt;
                            rdata     <= '0;
                            gnt       <= '0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    gnt       <= '0;
                    hsel      <= 1'b0;
                    htrans    <= HTRANS_IDLE;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
